// File: rtl/pipe_issue_unit_if.sv
// Host-side push bus and pipeline-side issue bus of the instruction issue unit.
interface pipe_issue_unit_if;
  logic        wr_en;
  logic [23:0] wr_instr;
  logic        hold;
  logic        full;
  logic        empty;
  logic        overflow;
  logic        issue_valid;
  logic [3:0]  rs1;
  logic [3:0]  rs2;
  logic [3:0]  rd;
  logic [3:0]  func;
  logic [7:0]  addr;
  logic [15:0] issued_count;
  logic [15:0] stall_cycles;

  modport master (
    output wr_en, wr_instr, hold,
    input  full, empty, overflow, issue_valid, rs1, rs2, rd, func, addr,
           issued_count, stall_cycles
  );

  modport slave (
    input  wr_en, wr_instr, hold,
    output full, empty, overflow, issue_valid, rs1, rs2, rd, func, addr,
           issued_count, stall_cycles
  );
endinterface

// File: rtl/pipe_issue_unit.sv
// Instruction issue front-end: FIFO of packed instructions, RAW scoreboard that
// inserts bubbles until a producer's writeback is visible, issue/stall counters.
module pipe_issue_unit #(
  parameter int DEPTH  = 8,
  parameter int WB_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  pipe_issue_unit_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [23:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;
  logic          r_full;
  logic          r_empty;
  logic          r_overflow;

  logic          r_issue_valid;
  logic [3:0]    r_rs1;
  logic [3:0]    r_rs2;
  logic [3:0]    r_rd;
  logic [3:0]    r_func;
  logic [7:0]    r_addr;
  logic [15:0]   r_issued_count;
  logic [15:0]   r_stall_cycles;

  logic [WB_LAT-1:0] r_sb_v;
  logic [3:0]        r_sb_rd [WB_LAT];

  logic [23:0]   w_head;
  logic          w_push;
  logic          w_raw;
  logic          w_hazard;
  logic          w_pop;
  logic          w_stall;

  assign w_head   = r_mem[r_rptr];
  assign w_push   = bus.wr_en & ~r_full;
  assign w_hazard = ~r_empty & w_raw;
  assign w_pop    = ~bus.hold & ~r_empty & ~w_hazard;
  assign w_stall  = ~bus.hold & w_hazard;

  // RAW check of the current head sources against every in-flight destination
  always_comb begin
    w_raw = 1'b0;
    for (int i = 0; i < WB_LAT; i++) begin
      if (r_sb_v[i] && ((r_sb_rd[i] == w_head[15:12]) || (r_sb_rd[i] == w_head[11:8]))) begin
        w_raw = 1'b1;
      end else begin
        w_raw = w_raw;
      end
    end
  end

  // Next FIFO occupancy from the push/pop pair
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage array; left unreset since only entries below r_count are ever read
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= bus.wr_instr;
    end
  end

  // FIFO pointers, occupancy flags and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(DEPTH));
      r_empty <= (w_count_nxt == CW'(0));
      // A push against a full FIFO is lost even if a pop frees a slot this edge
      if (bus.wr_en && r_full) r_overflow <= 1'b1;
    end
  end

  // Scoreboard shift register: one slot per cycle until writeback is visible
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sb_v <= '0;
      for (int i = 0; i < WB_LAT; i++) r_sb_rd[i] <= 4'd0;
    end else if (!bus.hold) begin
      r_sb_v[0]  <= w_pop;
      r_sb_rd[0] <= w_head[19:16];
      for (int i = 1; i < WB_LAT; i++) begin
        r_sb_v[i]  <= r_sb_v[i-1];
        r_sb_rd[i] <= r_sb_rd[i-1];
      end
    end
  end

  // Issue register and statistics; fields hold their value across bubbles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_issue_valid  <= 1'b0;
      r_rs1          <= 4'd0;
      r_rs2          <= 4'd0;
      r_rd           <= 4'd0;
      r_func         <= 4'd0;
      r_addr         <= 8'd0;
      r_issued_count <= 16'd0;
      r_stall_cycles <= 16'd0;
    end else begin
      r_issue_valid <= w_pop;
      if (w_pop) begin
        r_func         <= w_head[23:20];
        r_rd           <= w_head[19:16];
        r_rs1          <= w_head[15:12];
        r_rs2          <= w_head[11:8];
        r_addr         <= w_head[7:0];
        r_issued_count <= r_issued_count + 16'd1;
      end
      if (w_stall && (r_stall_cycles != 16'hFFFF)) begin
        r_stall_cycles <= r_stall_cycles + 16'd1;
      end
    end
  end

  assign bus.full         = r_full;
  assign bus.empty        = r_empty;
  assign bus.overflow     = r_overflow;
  assign bus.issue_valid  = r_issue_valid;
  assign bus.rs1          = r_rs1;
  assign bus.rs2          = r_rs2;
  assign bus.rd           = r_rd;
  assign bus.func         = r_func;
  assign bus.addr         = r_addr;
  assign bus.issued_count = r_issued_count;
  assign bus.stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipe_issue_unit.sv
// Directed bench for pipe_issue_unit: queue/ready-time model checked every cycle,
// plus literal expectations on issue spacing, counters and flags per scenario.
module tb_pipe_issue_unit;
  localparam int DEPTH  = 8;
  localparam int WB_LAT = 2;

  logic clk;
  logic rst;
  pipe_issue_unit_if bus ();

  pipe_issue_unit #(.DEPTH(DEPTH), .WB_LAT(WB_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] mk(input int f, input int d, input int s1, input int s2, input int a);
    mk = {f[3:0], d[3:0], s1[3:0], s2[3:0], a[7:0]};
  endfunction

  // Model: FIFO as a queue; a register is readable from active edge ready_at[r] on
  logic [23:0] q[$];
  logic        m_valid = 1'b0;
  logic [23:0] m_f = 24'd0;
  logic [15:0] m_issued = 16'd0;
  logic [15:0] m_stall = 16'd0;
  logic        m_ovf = 1'b0;
  int          ae = 0;
  int          ready_at [16];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_valid = 1'b0; m_f = 24'd0; m_issued = 16'd0; m_stall = 16'd0; m_ovf = 1'b0;
      ae = 0;
      for (int r = 0; r < 16; r++) ready_at[r] = 0;
    end else begin
      int old_size;
      logic [23:0] h;
      old_size = q.size();
      m_valid  = 1'b0;
      if (!bus.hold) begin
        if (old_size > 0) begin
          h = q[0];
          if (ready_at[h[15:12]] > ae || ready_at[h[11:8]] > ae) begin
            if (m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
          end else begin
            void'(q.pop_front());
            m_valid = 1'b1;
            m_f = h;
            ready_at[h[19:16]] = ae + WB_LAT + 1;
            m_issued = m_issued + 16'd1;
          end
        end
        ae++;
      end
      if (bus.wr_en) begin
        if (old_size == DEPTH) m_ovf = 1'b1;
        else q.push_back(bus.wr_instr);
      end
    end
  end

  typedef struct { int cyc; logic [23:0] f; } issue_t;
  issue_t ilog[$];
  int cyc = 0;

  // Every-cycle comparison against the model, plus issue trace for literal checks
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      logic [23:0] fo;
      fo = {bus.func, bus.rd, bus.rs1, bus.rs2, bus.addr};
      chk("issue_valid", bus.issue_valid, m_valid);
      chk("fields", fo, m_f);
      chk("issued_count", bus.issued_count, m_issued);
      chk("stall_cycles", bus.stall_cycles, m_stall);
      chk("full", bus.full, (q.size() == DEPTH));
      chk("empty", bus.empty, (q.size() == 0));
      chk("overflow", bus.overflow, m_ovf);
      if (bus.issue_valid) ilog.push_back('{cyc: cyc, f: fo});
    end
  end

  task automatic push(input logic [23:0] ins);
    bus.wr_en = 1'b1;
    bus.wr_instr = ins;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    ilog.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.wr_en = 1'b0;
    bus.wr_instr = 24'd0;
    bus.hold = 1'b0;
    #1;
    chk("rst0_valid", bus.issue_valid, 1'b0);
    chk("rst0_empty", bus.empty, 1'b1);
    chk("rst0_full", bus.full, 1'b0);
    chk("rst0_cnt", bus.issued_count, 16'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-stream
    push(mk(1, 10, 3, 5, 8'h10));
    push(mk(3, 11, 4, 6, 8'h11));
    push(mk(2, 12, 7, 8, 8'h12));
    #2;
    rst = 1'b1;
    #1;
    chk("amid_valid", bus.issue_valid, 1'b0);
    chk("amid_empty", bus.empty, 1'b1);
    chk("amid_cnt", bus.issued_count, 16'd0);
    chk("amid_fields", {bus.func, bus.rd, bus.rs1, bus.rs2, bus.addr}, 24'd0);
    ilog.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("amid_nostale", ilog.size(), 0);
    chk("amid_cnt2", bus.issued_count, 16'd0);

    // Independent back-to-back stream
    do_reset();
    push(mk(1, 10, 3, 5, 125));
    push(mk(3, 12, 3, 8, 126));
    repeat (3) @(negedge clk);
    chk("ind_n", ilog.size(), 2);
    if (ilog.size() == 2) begin
      chk("ind_f0", ilog[0].f, 24'h1A357D);
      chk("ind_f1", ilog[1].f, 24'h3C387E);
      chk("ind_gap", ilog[1].cyc - ilog[0].cyc, 1);
    end
    chk("ind_cnt", bus.issued_count, 16'd2);
    chk("ind_stall", bus.stall_cycles, 16'd0);

    // RAW stall: two bubbles
    do_reset();
    push(mk(1, 10, 3, 5, 0));
    push(mk(2, 14, 10, 5, 1));
    repeat (5) @(negedge clk);
    chk("raw_n", ilog.size(), 2);
    if (ilog.size() == 2) chk("raw_gap", ilog[1].cyc - ilog[0].cyc, 3);
    chk("raw_stall", bus.stall_cycles, 16'd2);

    // rs2 hazard with one intervening instruction -> one bubble
    do_reset();
    push(mk(1, 13, 1, 2, 0));
    push(mk(3, 9, 4, 6, 1));
    push(mk(4, 15, 7, 13, 2));
    repeat (4) @(negedge clk);
    chk("rs2_n", ilog.size(), 3);
    if (ilog.size() == 3) chk("rs2_gap", ilog[2].cyc - ilog[1].cyc, 2);
    chk("rs2_stall", bus.stall_cycles, 16'd1);

    // Gap of WB_LAT independents -> no stall
    do_reset();
    push(mk(1, 13, 1, 2, 0));
    push(mk(3, 9, 4, 6, 1));
    push(mk(3, 8, 4, 6, 2));
    push(mk(4, 15, 7, 13, 3));
    repeat (3) @(negedge clk);
    chk("exp_n", ilog.size(), 4);
    if (ilog.size() == 4) chk("exp_gap", ilog[3].cyc - ilog[0].cyc, 3);
    chk("exp_stall", bus.stall_cycles, 16'd0);

    // Full / overflow under hold
    do_reset();
    bus.hold = 1'b1;
    for (int i = 0; i < 8; i++) push(mk(5, 2 + i, 0, 1, 8'h40 + i));
    chk("ful_full", bus.full, 1'b1);
    chk("ful_ovf0", bus.overflow, 1'b0);
    push(mk(6, 15, 0, 1, 8'hFF));
    chk("ful_ovf1", bus.overflow, 1'b1);
    repeat (3) @(negedge clk);
    chk("ful_ovf_sticky", bus.overflow, 1'b1);
    chk("ful_none", ilog.size(), 0);
    bus.hold = 1'b0;
    repeat (10) @(negedge clk);
    chk("ful_n", ilog.size(), 8);
    for (int i = 0; i < ilog.size() && i < 8; i++) begin
      chk("ful_order", ilog[i].f, mk(5, 2 + i, 0, 1, 8'h40 + i));
    end
    if (ilog.size() == 8) chk("ful_gap", ilog[7].cyc - ilog[0].cyc, 7);
    chk("ful_cnt", bus.issued_count, 16'd8);
    chk("ful_empty", bus.empty, 1'b1);
    chk("ful_ovf_end", bus.overflow, 1'b1);

    // Hold in the middle of a hazard stall
    do_reset();
    push(mk(1, 10, 3, 5, 0));
    push(mk(2, 14, 10, 5, 1));
    @(negedge clk);
    chk("hh_stall1", bus.stall_cycles, 16'd1);
    bus.hold = 1'b1;
    repeat (5) @(negedge clk);
    chk("hh_frozen", bus.stall_cycles, 16'd1);
    chk("hh_n1", ilog.size(), 1);
    bus.hold = 1'b0;
    repeat (4) @(negedge clk);
    chk("hh_n2", ilog.size(), 2);
    if (ilog.size() == 2) chk("hh_gap", ilog[1].cyc - ilog[0].cyc, 8);
    chk("hh_stall2", bus.stall_cycles, 16'd2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/pipe_issue_unit.md
Name: pipe_issue_unit

Overview:
- Instruction issue front-end for the 4-stage register/ALU/writeback/memory pipeline; it is the initiator that drives rs1/rs2/rd/func/addr into that pipeline.
- A host pushes packed instructions into an internal FIFO. The block issues at most one instruction per cycle.
- A RAW scoreboard inserts bubbles while a source register is still awaiting writeback.
- It keeps issue and stall statistics.

Parameters:
DEPTH, 8, instruction FIFO entries (power of 2, >=2)
WB_LAT, 2, cycles after issue before the pipeline regbank write is visible to a new issue

Ports:
clk  input  1  single system clock, rising-edge
rst  input  1  asynchronous, active-high reset
wr_en  input  1  push wr_instr into FIFO
wr_instr  input  24  {func[23:20], rd[19:16], rs1[15:12], rs2[11:8], addr[7:0]}
hold  input  1  freeze issue (no pop, no scoreboard advance)
full  output  1  FIFO full
empty  output  1  FIFO empty
overflow  output  1  sticky: push attempted while full
issue_valid  output  1  outputs below carry a new instruction this cycle
rs1  output  4  source register 1
rs2  output  4  source register 2
rd  output  4  destination register
func  output  4  ALU function code
addr  output  8  memory write address
issued_count  output  16  instructions issued, wraps
stall_cycles  output  16  hazard bubble cycles, saturates at 16'hFFFF

Behaviour:
- Reset (async, any time, including mid-operation):
  - FIFO pointers and count cleared; scoreboard cleared.
  - issue_valid=0; rs1/rs2/rd/func/addr=0; counters=0; overflow=0; full=0; empty=1.
- Push:
  - If wr_en and not full at the edge, the entry is written at the tail.
  - If wr_en while full, the write is dropped and overflow is set. This applies even when a pop occurs the same cycle.
  - Push and pop in the same cycle are allowed when not full.
  - Pointers wrap modulo DEPTH.
- No bypass: an instruction pushed at edge k is first issuable at edge k+1, so issue_valid is high after edge k+1 at the earliest.
- Scoreboard:
  - Shift register of WB_LAT slots, each {v, rd}.
  - Every edge with hold=0, slot0 <= {issued_this_edge, issued rd} and slot i <= slot i-1; the last slot drops out.
  - With hold=1 the scoreboard freezes.
- Hazard: FIFO not empty, and some valid slot has rd equal to head rs1 or head rs2. The comparison is combinational on the current head.
- Issue decision at each edge:
  - If hold=1: issue_valid <= 0; nothing popped; stall_cycles unchanged.
  - Else if empty: issue_valid <= 0.
  - Else if hazard: issue_valid <= 0; stall_cycles += 1 (saturating).
  - Else: pop head; drive its fields onto rs1/rs2/rd/func/addr; issue_valid <= 1; issued_count += 1 (wrapping).
- Bubbles: when issue_valid=0, field outputs hold their previous values; the pipeline qualifies on issue_valid.
- Dependent-issue latency: a dependent instruction issued WB_LAT+1 edges after its producer sees no hazard. The default gives 2 bubbles.
- Independent instructions: back-to-back issue, 1 per cycle.
- No hazard check on rd/rd (WAW) or on addr.

Test Plan:
- Reset mid-stream: push 3 instructions, assert rst between edges -> outputs and counters 0, empty=1 immediately (asynchronous); after release, no stale instruction issues.
- Independent stream: push {ADD 3,5->10 @125}, {MUL 3,8->12 @126} on consecutive cycles -> issue_valid high on 2 consecutive cycles with exact fields; issued_count=2; stall_cycles=0.
- RAW stall: push ADD rs1=3,rs2=5,rd=10 then SUB rs1=10,rs2=5,rd=14 together -> ADD issues at edge t, SUB at edge t+3; issue_valid low at t+1 and t+2; stall_cycles=2.
- rs2 hazard and expiry: ADD ->13, then an independent instruction, then SLA rs1=7,rs2=13 -> exactly one bubble before SLA; no stall when the gap is >= WB_LAT.
- Full/overflow: push 9 instructions with hold=1 -> full=1 after 8; 9th dropped, overflow=1 and sticky; release hold -> exactly 8 issue, in order.
- Hold during hazard: hold=1 for 5 cycles while SUB is stalled -> stall_cycles unchanged, scoreboard frozen; after hold=0, SUB still waits its remaining bubble cycles.
